stream_monitor: RTL and testbench

//  Pipelined self-checking monitor for arithmetic DUTs. Samples DUT operands and result each valid cycle,

---
 rtl/stream_monitor.sv | 185 ++++++++++++++++++
 tb/tb_stream_monitor.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_monitor.sv
// stream_monitor: in-order pipelined reference checker for arithmetic DUT result streams.
// Optional macro STREAM_MONITOR_TOLERANCE_EN adds i_tol and a signed-distance compare.
module stream_monitor #(
    parameter int WIDTH       = 32,
    parameter int OP          = 0,
    parameter int REF_LAT     = 2,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_dut_ia,
    input  logic [WIDTH-1:0] i_dut_ib,
    input  logic [WIDTH-1:0] i_dut_os,
`ifdef STREAM_MONITOR_TOLERANCE_EN
    input  logic [WIDTH-1:0] i_tol,
`endif
    input  logic             i_clear,
    output logic             o_mon_ready,
    output logic             o_chk_valid,
    output logic             o_mismatch,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_err_sticky,
    output logic [CNT_W-1:0] o_txn_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [WIDTH-1:0] o_first_a,
    output logic [WIDTH-1:0] o_first_b,
    output logic [WIDTH-1:0] o_first_os
);

    typedef enum logic [1:0] {WARM, RUN, HALT} state_t;

    localparam int                WARM_W    = $clog2(REF_LAT + 2);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(REF_LAT + 1);
    localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (OP)
            1:       ref_op = a - b;
            2:       ref_op = a * b;
            default: ref_op = a + b;
        endcase
    endfunction

    state_t             state;
    logic [WARM_W-1:0]  warm_cnt;

    logic               in_v;
    logic [WIDTH-1:0]   in_a, in_b, in_os;
    logic [REF_LAT-1:0] ref_v;
    logic [WIDTH-1:0]   ref_q [REF_LAT];
    logic [WIDTH-1:0]   a_q   [REF_LAT];
    logic [WIDTH-1:0]   b_q   [REF_LAT];
    logic [WIDTH-1:0]   os_q  [REF_LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_v  <= 1'b0;
            ref_v <= '0;
        end else begin
            in_v     <= i_valid && (state == RUN);
            ref_v[0] <= in_v;
            for (int i = 1; i < REF_LAT; i++) ref_v[i] <= ref_v[i-1];
        end
    end

    // NOTE: payload registers carry no reset; only the valid bits above decide what retires.
    always_ff @(posedge clk) begin
        in_a     <= i_dut_ia;
        in_b     <= i_dut_ib;
        in_os    <= i_dut_os;
        ref_q[0] <= ref_op(in_a, in_b);
        a_q[0]   <= in_a;
        b_q[0]   <= in_b;
        os_q[0]  <= in_os;
        for (int i = 1; i < REF_LAT; i++) begin
            ref_q[i] <= ref_q[i-1];
            a_q[i]   <= a_q[i-1];
            b_q[i]   <= b_q[i-1];
            os_q[i]  <= os_q[i-1];
        end
    end

    logic             tail_v, tail_mis;
    logic [WIDTH-1:0] tail_ref, tail_os, tail_diff;

    assign tail_v    = ref_v[REF_LAT-1];
    assign tail_ref  = ref_q[REF_LAT-1];
    assign tail_os   = os_q[REF_LAT-1];
    assign tail_diff = tail_os ^ tail_ref;

`ifdef STREAM_MONITOR_TOLERANCE_EN
    logic [WIDTH-1:0] in_tol;
    logic [WIDTH-1:0] tol_q [REF_LAT];
    logic [WIDTH-1:0] dist, dist_abs;

    always_ff @(posedge clk) begin
        in_tol   <= i_tol;
        tol_q[0] <= in_tol;
        for (int i = 1; i < REF_LAT; i++) tol_q[i] <= tol_q[i-1];
    end

    // Distance is taken modulo 2^WIDTH and read as two's complement before the magnitude test.
    assign dist     = tail_os - tail_ref;
    assign dist_abs = dist[WIDTH-1] ? -dist : dist;
    assign tail_mis = dist_abs > tol_q[REF_LAT-1];
`else
    assign tail_mis = tail_os != tail_ref;
`endif

    logic count_err;
    assign count_err = tail_v && tail_mis && !i_clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WARM;
            warm_cnt     <= '0;
            o_mon_ready  <= 1'b0;
            o_chk_valid  <= 1'b0;
            o_mismatch   <= 1'b0;
            o_diff       <= '0;
            o_err_sticky <= 1'b0;
            o_txn_cnt    <= '0;
            o_err_cnt    <= '0;
            o_first_a    <= '0;
            o_first_b    <= '0;
            o_first_os   <= '0;
        end else begin
            case (state)
                WARM: begin
                    if (warm_cnt == WARM_LAST) begin
                        state       <= RUN;
                        o_mon_ready <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + WARM_ONE;
                    end
                end
                RUN: begin
                    if (STOP_ON_ERR != 0 && count_err) begin
                        state       <= HALT;
                        o_mon_ready <= 1'b0;
                    end
                end
                HALT: begin
                    if (i_clear) begin
                        state       <= RUN;
                        o_mon_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= WARM;
                    o_mon_ready <= 1'b0;
                end
            endcase

            // The check pulse is always shown; a same-cycle clear only suppresses its bookkeeping.
            o_chk_valid <= tail_v;
            o_mismatch  <= tail_v && tail_mis;
            o_diff      <= tail_v ? tail_diff : '0;

            if (i_clear) begin
                o_err_sticky <= 1'b0;
                o_txn_cnt    <= '0;
                o_err_cnt    <= '0;
                o_first_a    <= '0;
                o_first_b    <= '0;
                o_first_os   <= '0;
            end else if (tail_v) begin
                if (o_txn_cnt != '1) o_txn_cnt <= o_txn_cnt + CNT_ONE;
                if (tail_mis) begin
                    if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_ONE;
                    o_err_sticky <= 1'b1;
                    if (!o_err_sticky) begin
                        o_first_a  <= a_q[REF_LAT-1];
                        o_first_b  <= b_q[REF_LAT-1];
                        o_first_os <= tail_os;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_monitor.sv
// Scoreboard bench for stream_monitor: three instances (add/STOP=0, sub/STOP=1, mul/CNT_W=4).
module tb_stream_monitor;
    localparam int W = 32;

    typedef struct {
        logic         m;
        logic [W-1:0] d;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [2:0]   valid, clear;
    logic [W-1:0] ia [3], ib [3], os [3];
`ifdef STREAM_MONITOR_TOLERANCE_EN
    logic [W-1:0] tol [3];
`endif
    logic [2:0]   ready, chk, mis, sticky;
    logic [W-1:0] diff [3], fa [3], fb [3], fos [3];
    logic [15:0]  txn0, err0, txn1, err1;
    logic [3:0]   txn2, err2;

    stream_monitor #(.WIDTH(W), .OP(0), .REF_LAT(2), .CNT_W(16), .STOP_ON_ERR(0)) u_add (
        .clk(clk), .reset_n(reset_n), .i_valid(valid[0]),
        .i_dut_ia(ia[0]), .i_dut_ib(ib[0]), .i_dut_os(os[0]),
`ifdef STREAM_MONITOR_TOLERANCE_EN
        .i_tol(tol[0]),
`endif
        .i_clear(clear[0]), .o_mon_ready(ready[0]), .o_chk_valid(chk[0]), .o_mismatch(mis[0]),
        .o_diff(diff[0]), .o_err_sticky(sticky[0]), .o_txn_cnt(txn0), .o_err_cnt(err0),
        .o_first_a(fa[0]), .o_first_b(fb[0]), .o_first_os(fos[0]));

    stream_monitor #(.WIDTH(W), .OP(1), .REF_LAT(1), .CNT_W(16), .STOP_ON_ERR(1)) u_sub (
        .clk(clk), .reset_n(reset_n), .i_valid(valid[1]),
        .i_dut_ia(ia[1]), .i_dut_ib(ib[1]), .i_dut_os(os[1]),
`ifdef STREAM_MONITOR_TOLERANCE_EN
        .i_tol(tol[1]),
`endif
        .i_clear(clear[1]), .o_mon_ready(ready[1]), .o_chk_valid(chk[1]), .o_mismatch(mis[1]),
        .o_diff(diff[1]), .o_err_sticky(sticky[1]), .o_txn_cnt(txn1), .o_err_cnt(err1),
        .o_first_a(fa[1]), .o_first_b(fb[1]), .o_first_os(fos[1]));

    stream_monitor #(.WIDTH(W), .OP(2), .REF_LAT(3), .CNT_W(4), .STOP_ON_ERR(0)) u_mul (
        .clk(clk), .reset_n(reset_n), .i_valid(valid[2]),
        .i_dut_ia(ia[2]), .i_dut_ib(ib[2]), .i_dut_os(os[2]),
`ifdef STREAM_MONITOR_TOLERANCE_EN
        .i_tol(tol[2]),
`endif
        .i_clear(clear[2]), .o_mon_ready(ready[2]), .o_chk_valid(chk[2]), .o_mismatch(mis[2]),
        .o_diff(diff[2]), .o_err_sticky(sticky[2]), .o_txn_cnt(txn2), .o_err_cnt(err2),
        .o_first_a(fa[2]), .o_first_b(fb[2]), .o_first_os(fos[2]));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    exp_t sb [3][$];
    exp_t mon_e;
    logic [W-1:0] a_r, b_r, r_r, m_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int op_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [W-1:0] model_ref(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            1:       return a - b;
            2:       return a * b;
            default: return a + b;
        endcase
    endfunction

    // Drives one transaction for one cycle; acc says whether the monitor should accept it.
    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] s, input bit acc, input logic [W-1:0] t = '0);
        exp_t e;
        logic [W-1:0] r;
        r     = model_ref(op_of(i), a, b);
        e.d   = s ^ r;
        e.due = cyc + lat_of(i) + 2;
`ifdef STREAM_MONITOR_TOLERANCE_EN
        begin
            logic [W-1:0] dd;
            dd = s - r;
            if (dd[W-1]) dd = -dd;
            e.m = dd > t;
            tol[i] = t;
        end
`else
        e.m = (s != r) || (t != t);
`endif
        valid[i] = 1'b1;
        ia[i] = a;
        ib[i] = b;
        os[i] = s;
        if (acc) sb[i].push_back(e);
        @(negedge clk);
        valid[i] = 1'b0;
    endtask

    task automatic pulse_clear(input int i);
        clear[i] = 1'b1;
        @(negedge clk);
        clear[i] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (sb[0].size() + sb[1].size() + sb[2].size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("drained%0d", i), sb[i].size(), 0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (chk[i]) begin
                if (sb[i].size() == 0) begin
                    check($sformatf("spurious_chk%0d", i), chk[i], 0);
                end else begin
                    mon_e = sb[i].pop_front();
                    check($sformatf("latency%0d", i), cyc, mon_e.due);
                    check($sformatf("mismatch%0d", i), mis[i], mon_e.m);
                    check($sformatf("diff%0d", i), diff[i], mon_e.d);
                end
            end else begin
                check($sformatf("idle_diff%0d", i), diff[i], 0);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        valid   = '0;
        clear   = '0;
        for (int i = 0; i < 3; i++) begin
            ia[i] = '0; ib[i] = '0; os[i] = '0;
`ifdef STREAM_MONITOR_TOLERANCE_EN
            tol[i] = '0;
`endif
        end
        repeat (3) @(negedge clk);

        check("rst_ready", ready, 0);
        check("rst_chk", chk, 0);
        check("rst_sticky", sticky, 0);
        check("rst_txn0", txn0, 0);
        check("rst_err2", err2, 0);
        check("rst_first_a1", fa[1], 0);

        // Hold i_valid high through warm-up: nothing may be accepted until ready.
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b1; ia[i] = 1; ib[i] = 2; os[i] = 7;
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("warm_ready%0d_e%0d", i, e), ready[i], (e >= lat_of(i) + 2));
                if (e == lat_of(i) + 2) valid[i] = 1'b0;
            end
        end

        // Back-to-back correct adds, plus a few correct multiplies.
        for (int k = 0; k < 100; k++) begin
            a_r = $urandom; b_r = $urandom;
            send(0, a_r, b_r, a_r + b_r, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            a_r = $urandom; b_r = $urandom; r_r = a_r * b_r;
            send(2, a_r, b_r, r_r, 1'b1);
        end
        drain();
        check("add_txn", txn0, 100);
        check("add_err", err0, 0);
        check("add_sticky", sticky[0], 0);
        check("mul_txn", txn2, 5);

        // First mismatch is captured; later ones leave the capture alone.
        send(0, 5, 3, 9, 1'b1);
        drain();
        check("cap_a", fa[0], 5);
        check("cap_b", fb[0], 3);
        check("cap_os", fos[0], 9);
        check("cap_err", err0, 1);
        check("cap_txn", txn0, 101);
        check("cap_sticky", sticky[0], 1);
        send(0, 32'h100, 32'h1, 32'h0, 1'b1);
        drain();
        check("cap_hold_a", fa[0], 5);
        check("cap_hold_os", fos[0], 9);
        check("cap_err2", err0, 2);

        // Stop-on-error: in-flight txns still retire, later ones are dropped until clear.
        send(1, 10, 3, 7, 1'b1);
        send(1, 10, 3, 6, 1'b1);
        send(1, 20, 5, 15, 1'b1);
        send(1, 30, 8, 22, 1'b1);
        send(1, 40, 1, 39, 1'b0);
        send(1, 50, 2, 48, 1'b0);
        drain();
        check("halt_ready", ready[1], 0);
        check("halt_txn", txn1, 4);
        check("halt_err", err1, 1);
        check("halt_first_os", fos[1], 6);
        send(1, 9, 9, 0, 1'b0);
        drain();
        check("halt_drop_txn", txn1, 4);
        pulse_clear(1);
        check("clr_ready", ready[1], 1);
        check("clr_txn", txn1, 0);
        check("clr_err", err1, 0);
        check("clr_sticky", sticky[1], 0);
        check("clr_first_a", fa[1], 0);
        send(1, 100, 1, 99, 1'b1);
        drain();
        check("run_txn", txn1, 1);
`ifdef STREAM_MONITOR_TOLERANCE_EN
        send(1, 10, 4, 8, 1'b1, 2);
        send(1, 10, 4, 3, 1'b1, 2);
        drain();
        check("tol_err", err1, 1);
        check("tol_first_os", fos[1], 3);
`endif

        // Saturation with 4-bit counters, then a clear landing on a retiring mismatch.
        for (int k = 0; k < 20; k++) begin
            a_r = $urandom; b_r = $urandom; r_r = a_r * b_r; m_r = $urandom | 1;
            send(2, a_r, b_r, r_r ^ m_r, 1'b1);
        end
        drain();
        check("sat_txn", txn2, 15);
        check("sat_err", err2, 15);
        check("sat_sticky", sticky[2], 1);
        a_r = 11; b_r = 13; r_r = a_r * b_r;
        send(2, a_r, b_r, r_r ^ 4, 1'b1);
        repeat (lat_of(2)) @(negedge clk);
        pulse_clear(2);
        drain();
        check("clrret_txn", txn2, 0);
        check("clrret_err", err2, 0);
        check("clrret_sticky", sticky[2], 0);
        check("clrret_first_a", fa[2], 0);
        send(2, 7, 6, 41, 1'b1);
        drain();
        check("recap_err", err2, 1);
        check("recap_a", fa[2], 7);
        check("recap_os", fos[2], 41);

        // Reset with transactions in flight: they must never retire.
        send(0, 1, 1, 2, 1'b0);
        send(0, 2, 2, 4, 1'b0);
        send(0, 3, 3, 6, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_chk", chk[0], 0);
        check("midrst_txn", txn0, 0);
        check("midrst_ready", ready[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst_txn", txn0, 0);
        check("postrst_ready", ready[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
